pulse_timer_bank: RTL and testbench
===================================

# pulse_timer_bank

Multi-channel programmable pulse timer, the parametrised successor to the single fixed-duration pulse generator. A shared prescaler derives a base tick from the system clock, and each of CHANNELS independent channels counts a runtime-programmable number of ticks before emitting a one-clock pulse. Each channel runs in periodic or one-shot mode and supports start, restart, pause and abort. It sits beside the control/sequencing logic and feeds its strobes: sample triggers, UI refresh, timeouts.

## Interface
- CHANNELS, 4: number of independent channels (1..16).
- CLOCK_FREQUENCY, 50000000: clock frequency in Hz.
- TICK_HZ, 1000: base tick rate; PRESCALE = CLOCK_FREQUENCY/TICK_HZ must be an exact integer ≥ 2, otherwise elaboration fails.
- PERIOD_WIDTH, 16: width of each channel's period field, in ticks.
- clock  in  1  system clock. Single clock domain.
- reset  in  1  synchronous, active-high reset.
- start  in  CHANNELS  per-channel arm/restart strobe, one cycle.
- oneshot  in  CHANNELS  mode, sampled on start: 1 = one-shot, 0 = periodic.
- enable  in  CHANNELS  level; 0 pauses a running channel.
- period  in  CHANNELS*PERIOD_WIDTH  channel i at [i*PERIOD_WIDTH +: PERIOD_WIDTH], sampled on start.
- out  out  CHANNELS  one-cycle expiry pulse per channel.
- active  out  CHANNELS  channel i is in RUN.
- tick  out  1  shared prescaler tick, one cycle every PRESCALE clocks.

## Operation
- Prescaler: counts 0..PRESCALE-1 and wraps; it free-runs from reset regardless of channel state. tick = (prescaler == PRESCALE-1), combinational from the register.
- Channel FSM has two states, IDLE and RUN. Each channel holds remain[PERIOD_WIDTH], a latched period and a latched mode.
- IDLE, start=1, period≠0: latch period and mode, remain ← period, go to RUN.
- IDLE, start=1, period=0: ignored; stays IDLE.
- RUN, start=1, period≠0: restart. Reload and relatch; no out this cycle, even if tick is also high.
- RUN, start=1, period=0: abort to IDLE; no out.
- RUN, no start, enable=1, tick=1, remain>1: remain ← remain-1.
- RUN, no start, enable=1, tick=1, remain==1:
  - out pulses.
  - Periodic: remain ← latched period; stays in RUN.
  - One-shot: go to IDLE.
- RUN, enable=0: remain frozen; ticks are lost, not queued. The prescaler is not affected.
- A change on period or oneshot while in RUN has no effect until the next start.
- Channels are fully independent. Simultaneous expiries on several channels all pulse in the same cycle.
- Maximum period is 2^PERIOD_WIDTH-1 ticks. There is no wrap-around in remain.

## Timing
- Reset:
  - prescaler = 0
  - all channels IDLE, remain = 0
  - out = 0, active = 0
  - tick = 0 in the cycle after reset
- Reset mid-operation aborts every channel immediately; no out is issued in the reset cycle or the cycle after it.
- start in cycle c: active=1 from cycle c+1. Ticks in cycle c itself are not counted.
- out is registered: it is high in the cycle after the tick cycle that takes remain from 1. It is high for exactly one clock.
- Periodic spacing: consecutive out pulses are exactly period*PRESCALE clocks apart while enable stays 1.
- First out after start: between (period-1)*PRESCALE+1 and period*PRESCALE clocks after c+1, depending on prescaler phase.
- One-shot: active drops in the same cycle that out rises.

## Structure
- Shared package/include `pulse_timer_pkg`:
  - state encodings ST_IDLE, ST_RUN
  - PRESCALE computation and divisibility check
  - prescaler width macro, $clog2(PRESCALE)
- Sub-module `pulse_timer_channel`:
  - one FSM plus remain register
  - instantiated CHANNELS times via generate
- The prescaler uses the existing `counter` module with a synchronous clear at PRESCALE-1.

## Test plan
All scenarios use CLOCK_FREQUENCY=1000, TICK_HZ=250 (PRESCALE=4), CHANNELS=2, PERIOD_WIDTH=8.
- Reset: hold reset 3 cycles, then release → out=0, active=0; first tick exactly 4 clocks after release.
- Periodic: ch0 start with period=3, oneshot=0 → out[0] pulses every 12 clocks; active[0] stays 1; 5 pulses checked.
- One-shot: ch1 start with period=2, oneshot=1 → exactly one out[1] pulse; active[1] falls in the same cycle; no further pulses over 40 clocks.
- Pause: ch0 periodic, period=2; deassert enable for 8 clocks mid-count → the next out is delayed by exactly 8 clocks (2 ticks); spacing afterwards is back to 8.
- Restart/abort:
  - start with period=5 in the same cycle as the remain==1 tick → no out; the next out comes 5 ticks later.
  - start with period=0 in RUN → active=0 next cycle.
- Independence: both channels periodic, periods 2 and 4, started together → coincident pulses every 16 clocks; reset asserted mid-count clears both with no stray out.

Source files
------------

// File: rtl/pulse_timer_pkg.sv
// Shared definitions for the pulse timer bank: channel state encoding and
// prescaler sizing helpers evaluated at elaboration time.
package pulse_timer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ch_state_e;

  // Clocks per base tick; guarded so a zero tick rate cannot divide by zero.
  function automatic int calc_prescale(int clk_hz, int tick_hz);
    return (tick_hz > 0) ? (clk_hz / tick_hz) : 0;
  endfunction

  // The tick rate must divide the clock exactly and give at least two clocks per tick.
  function automatic bit prescale_ok(int clk_hz, int tick_hz);
    return (tick_hz > 0) && (clk_hz % tick_hz == 0) && (clk_hz / tick_hz >= 2);
  endfunction

  // Prescaler register width, $clog2(PRESCALE) with a floor of one bit.
  function automatic int prescale_w(int prescale);
    return (prescale <= 2) ? 1 : $clog2(prescale);
  endfunction

endpackage

// File: rtl/pulse_timer_bank_if.sv
// Control/strobe bundle between the sequencing logic (master) and the timer bank (slave).
interface pulse_timer_bank_if #(
  parameter int CHANNELS     = 4,
  parameter int PERIOD_WIDTH = 16
);
  logic [CHANNELS-1:0]              start;
  logic [CHANNELS-1:0]              oneshot;
  logic [CHANNELS-1:0]              enable;
  logic [CHANNELS*PERIOD_WIDTH-1:0] period;
  logic [CHANNELS-1:0]              out;
  logic [CHANNELS-1:0]              active;
  logic                             tick;

  modport master (output start, oneshot, enable, period, input out, active, tick);
  modport slave  (input start, oneshot, enable, period, output out, active, tick);
endinterface

// File: rtl/counter.sv
// Free-running up counter with synchronous clear and count enable.
module counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] cnt_o
);
  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Clear has priority over counting.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  // Count register, synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/pulse_timer_channel.sv
// One timer channel: IDLE/RUN FSM, tick-down remain counter, latched period and mode.
module pulse_timer_channel
  import pulse_timer_pkg::*;
#(
  parameter int PERIOD_WIDTH = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    tick_i,
  input  logic                    start_i,
  input  logic                    oneshot_i,
  input  logic                    enable_i,
  input  logic [PERIOD_WIDTH-1:0] period_i,
  output logic                    out_o,
  output logic                    active_o
);
  localparam logic [PERIOD_WIDTH-1:0] ONE = PERIOD_WIDTH'(1);

  ch_state_e               state_q;
  logic [PERIOD_WIDTH-1:0] remain_q;
  logic [PERIOD_WIDTH-1:0] period_q;
  logic                    mode_q;   // 1 = one-shot
  logic                    out_q;

  // Channel FSM; start outranks tick so a restart never emits a pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      remain_q <= '0;
      period_q <= '0;
      mode_q   <= 1'b0;
      out_q    <= 1'b0;
    end else begin
      out_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start_i && (period_i != '0)) begin
            period_q <= period_i;
            mode_q   <= oneshot_i;
            remain_q <= period_i;
            state_q  <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (start_i) begin
            if (period_i != '0) begin
              period_q <= period_i;
              mode_q   <= oneshot_i;
              remain_q <= period_i;
            end else begin
              remain_q <= '0;
              state_q  <= ST_IDLE;
            end
          end else if (enable_i && tick_i) begin
            if (remain_q == ONE) begin
              out_q <= 1'b1;
              if (mode_q) begin
                remain_q <= '0;
                state_q  <= ST_IDLE;
              end else begin
                remain_q <= period_q;
              end
            end else begin
              remain_q <= remain_q - ONE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_o    = out_q;
  assign active_o = (state_q == ST_RUN);
endmodule

// File: rtl/pulse_timer_bank.sv
// Multi-channel pulse timer: shared prescaler tick feeding CHANNELS independent timers.
module pulse_timer_bank
  import pulse_timer_pkg::*;
#(
  parameter int CHANNELS        = 4,
  parameter int CLOCK_FREQUENCY = 50000000,
  parameter int TICK_HZ         = 1000,
  parameter int PERIOD_WIDTH    = 16
) (
  input  logic              clock,
  input  logic              reset,
  pulse_timer_bank_if.slave bus
);
  localparam int PRESCALE = calc_prescale(CLOCK_FREQUENCY, TICK_HZ);
  localparam int PSW      = prescale_w(PRESCALE);
  localparam logic [PSW-1:0] PRESC_LAST = PSW'(PRESCALE - 1);

  if (!prescale_ok(CLOCK_FREQUENCY, TICK_HZ)) begin : g_bad_prescale
    $error("pulse_timer_bank: CLOCK_FREQUENCY/TICK_HZ must be an exact integer >= 2");
  end
  if ((CHANNELS < 1) || (CHANNELS > 16)) begin : g_bad_channels
    $error("pulse_timer_bank: CHANNELS must be 1..16");
  end

  logic [PSW-1:0] presc;
  logic           tick;

  // Prescaler free-runs from reset and wraps on its last count.
  counter #(.WIDTH(PSW)) u_presc (
    .clk_i (clock),
    .rst_i (reset),
    .en_i  (1'b1),
    .clr_i (tick),
    .cnt_o (presc)
  );

  assign tick     = (presc == PRESC_LAST);
  assign bus.tick = tick;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    pulse_timer_channel #(.PERIOD_WIDTH(PERIOD_WIDTH)) u_ch (
      .clk_i     (clock),
      .rst_i     (reset),
      .tick_i    (tick),
      .start_i   (bus.start[i]),
      .oneshot_i (bus.oneshot[i]),
      .enable_i  (bus.enable[i]),
      .period_i  (bus.period[i*PERIOD_WIDTH +: PERIOD_WIDTH]),
      .out_o     (bus.out[i]),
      .active_o  (bus.active[i])
    );
  end
endmodule

// File: tb/tb_pulse_timer_bank.sv
// Bench for pulse_timer_bank: PRESCALE=4, two 8-bit channels. Expected pulse
// cycles are pushed per channel when a channel is armed; a negedge monitor pops
// and compares every observed out pulse.
module tb_pulse_timer_bank;
  localparam int CH  = 2;
  localparam int PW  = 8;
  localparam int PRE = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  pulse_timer_bank_if #(.CHANNELS(CH), .PERIOD_WIDTH(PW)) bus ();

  pulse_timer_bank #(
    .CHANNELS(CH), .CLOCK_FREQUENCY(1000), .TICK_HZ(250), .PERIOD_WIDTH(PW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int t0      = 0;   // first cycle after reset release (prescaler == 0)
  bit mon_en  = 1'b0;
  int exp_q0[$];
  int exp_q1[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int next_tick(input int c);
    return c + ((PRE - 1 - ((c - t0) % PRE) + PRE) % PRE);
  endfunction

  task automatic push_exp(input int ch, input int c);
    if (ch == 0) exp_q0.push_back(c);
    else         exp_q1.push_back(c);
  endtask

  task automatic go(input int target);
    while (cyc < target) @(negedge clock);
  endtask

  // Drive a one-cycle start in the current cycle; returns that cycle.
  task automatic arm(input int ch, input int p, input bit os, output int c);
    c = cyc;
    bus.start[ch] = 1'b1;
    bus.oneshot[ch] = os;
    bus.period[ch*PW +: PW] = PW'(p);
    @(negedge clock);
    bus.start[ch] = 1'b0;
  endtask

  // Scoreboard monitor: every out pulse must match the head of its channel queue.
  always @(negedge clock) begin : mon
    int e;
    if (mon_en) begin
      for (int ch = 0; ch < CH; ch++) begin
        if (bus.out[ch] !== 1'b0) begin
          n_tests++;
          if ((ch == 0 && exp_q0.size() == 0) || (ch == 1 && exp_q1.size() == 0)) begin
            n_fail++;
            $display("FAIL stray_out ch%0d: pulse at cycle %0d, none expected", ch, cyc);
          end else begin
            e = (ch == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            if (e != cyc) begin
              n_fail++;
              $display("FAIL out_cycle ch%0d: pulse at cycle %0d, expected %0d", ch, cyc, e);
            end
          end
        end
      end
    end
  end

  typedef struct {
    int ch;
    int period;
    bit os;
    int npulses;
  } vec_t;

  vec_t vt[5];

  initial begin : main
    int c, c2, fo, last, t1, e, found;
    vt[0] = '{ch: 0, period: 3,   os: 1'b0, npulses: 5};
    vt[1] = '{ch: 1, period: 2,   os: 1'b1, npulses: 1};
    vt[2] = '{ch: 1, period: 1,   os: 1'b0, npulses: 3};
    vt[3] = '{ch: 0, period: 1,   os: 1'b1, npulses: 1};
    vt[4] = '{ch: 0, period: 255, os: 1'b1, npulses: 1};

    reset = 1'b1;
    bus.start = '0; bus.oneshot = '0; bus.enable = '1; bus.period = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    t0 = cyc;
    check("reset_out", 32'(bus.out), 0);
    check("reset_active", 32'(bus.active), 0);
    check("reset_tick", 32'(bus.tick), 0);
    // First tick: 4 cycles after the last reset cycle (t0-1).
    found = -1;
    for (int n = 0; n < 8 && found < 0; n++) begin
      if (bus.tick === 1'b1) found = cyc;
      else @(negedge clock);
    end
    check("first_tick_delay", 32'(found - (t0 - 1)), 4);
    mon_en = 1'b1;

    // Table-driven single-channel runs.
    for (int i = 0; i < 5; i++) begin
      arm(vt[i].ch, vt[i].period, vt[i].os, c);
      check("tbl_active_on", 32'(bus.active[vt[i].ch]), 1);
      fo = next_tick(c + 1) + PRE * (vt[i].period - 1) + 1;
      for (int k = 0; k < vt[i].npulses; k++) push_exp(vt[i].ch, fo + k * PRE * vt[i].period);
      last = fo + (vt[i].npulses - 1) * PRE * vt[i].period;
      go(last);
      check("tbl_active_at_out", 32'(bus.active[vt[i].ch]), vt[i].os ? 0 : 1);
      if (!vt[i].os) begin
        arm(vt[i].ch, 0, 1'b0, c);
        check("tbl_abort_active", 32'(bus.active[vt[i].ch]), 0);
      end else begin
        go(cyc + 40);
        check("tbl_oneshot_idle", 32'(bus.active[vt[i].ch]), 0);
      end
      check("tbl_missing_pulses", 32'(exp_q0.size() + exp_q1.size()), 0);
    end

    // start with period 0 while IDLE is ignored.
    arm(1, 0, 1'b0, c);
    check("idle_zero_start", 32'(bus.active[1]), 0);

    // Pause: enable low for 8 clocks right after a pulse costs exactly 2 ticks.
    arm(0, 2, 1'b0, c);
    fo = next_tick(c + 1) + PRE + 1;
    push_exp(0, fo);
    push_exp(0, fo + 16);
    push_exp(0, fo + 24);
    go(fo + 1);
    bus.enable[0] = 1'b0;
    go(fo + 9);
    bus.enable[0] = 1'b1;
    go(fo + 24);
    check("pause_active", 32'(bus.active[0]), 1);
    arm(0, 0, 1'b0, c);
    check("pause_missing", 32'(exp_q0.size()), 0);

    // Restart on the remain==1 tick: no pulse, next one 5 ticks later.
    arm(0, 2, 1'b0, c);
    fo = next_tick(c + 1) + PRE + 1;
    push_exp(0, fo);
    go(fo + 7);
    check("restart_tick_phase", 32'(bus.tick), 1);
    arm(0, 5, 1'b0, c2);
    e = next_tick(c2 + 1) + PRE * 4 + 1;
    check("restart_expect_calc", 32'(e - fo), 28);
    push_exp(0, e);
    go(e);
    arm(0, 0, 1'b0, c);
    check("restart_abort_active", 32'(bus.active[0]), 0);
    check("restart_missing", 32'(exp_q0.size()), 0);

    // Independence: periods 2 and 4 together, then reset mid-count.
    c = cyc;
    bus.start = '1; bus.oneshot = '0;
    bus.period = {8'd4, 8'd2};
    @(negedge clock);
    bus.start = '0;
    check("indep_active", 32'(bus.active), 3);
    t1 = next_tick(c + 1);
    for (int k = 0; k < 4; k++) push_exp(0, t1 + 5 + 8 * k);
    push_exp(1, t1 + 13);
    push_exp(1, t1 + 29);
    e = t1 + 29;
    go(e + 7);                 // ch0 would pulse at e+8
    reset = 1'b1;
    @(negedge clock);
    check("midreset_out", 32'(bus.out), 0);
    check("midreset_active", 32'(bus.active), 0);
    @(negedge clock);
    reset = 1'b0;
    t0 = cyc;
    check("postreset_out", 32'(bus.out), 0);
    go(cyc + 40);
    check("postreset_idle", 32'(bus.active), 0);
    check("indep_missing", 32'(exp_q0.size() + exp_q1.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
